char_stream_feeder: RTL and testbench

//  Upstream source stage for the if/else statement parser. Accepts raw 7-bit ASCII from a

---
 rtl/char_stream_feeder_if.sv | 42 ++++
 rtl/char_stream_feeder.sv | 183 ++++++++++++++++++
 tb/tb_char_stream_feeder.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/char_stream_feeder_if.sv
// Host-side and parser-side signal bundle for char_stream_feeder.
// master = host/parser environment, slave = the feeder.
interface char_stream_feeder_if #(
  parameter int ADDR_W = 4
);
  logic [6:0]      in_char;
  logic            in_valid;
  logic            in_ready;
  logic            out_en;
  logic            flush;
  logic [6:0]      ascii_char;
  logic            char_valid;
  logic            eos;
  logic [ADDR_W:0] fifo_count;
  logic            illegal_char;

  modport master (
    output in_char,
    output in_valid,
    output out_en,
    output flush,
    input  in_ready,
    input  ascii_char,
    input  char_valid,
    input  eos,
    input  fifo_count,
    input  illegal_char
  );

  modport slave (
    input  in_char,
    input  in_valid,
    input  out_en,
    input  flush,
    output in_ready,
    output ascii_char,
    output char_valid,
    output eos,
    output fifo_count,
    output illegal_char
  );
endinterface

// File: rtl/char_stream_feeder.sv
// Normalising ASCII FIFO feeding the if/else parser, one char per emit slot.
// Define FEEDER_CASE_FOLD_EN to store 'A'..'Z' as lowercase.
module char_stream_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int GAP    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  char_stream_feeder_if.slave  bus
);
  localparam int GW  = (GAP > 2) ? $clog2(GAP) : 1;
  localparam int GM1 = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_GAP
  } state_t;

  logic [6:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_count;
  state_t            r_state;
  state_t            w_next;
  logic [GW-1:0]     r_gap;
  logic [6:0]        r_char;
  logic              r_valid;
  logic              r_eos;
  logic              r_ill;
  logic              r_last_ws;

  logic              w_ready;
  logic              w_accept;
  logic              w_silent;
  logic              w_ws;
  logic              w_illegal;
  logic              w_push;
  logic              w_pop;
  logic              w_gap_load;
  logic [6:0]        w_store;
  logic [6:0]        w_head;

  assign w_ready  = (r_count < (ADDR_W+1)'(DEPTH))
                 && !bus.flush;
  assign w_accept = bus.in_valid && w_ready;
  assign w_head   = r_mem[r_rptr];

  always_comb begin
    w_silent  = (bus.in_char == 7'h00)
             || (bus.in_char == 7'h0D);
    w_ws      = (bus.in_char == 7'h20)
             || (bus.in_char == 7'h09)
             || (bus.in_char == 7'h0A);
    w_illegal = !w_silent && !w_ws
             && ((bus.in_char < 7'h20)
             || (bus.in_char == 7'h7F));
    w_store   = w_ws ? 7'h20 : bus.in_char;
`ifdef FEEDER_CASE_FOLD_EN
    if (bus.in_char >= 7'h41 && bus.in_char <= 7'h5A)
      w_store = bus.in_char + 7'h20;
`endif
    // runs of whitespace collapse to one space
    w_push = w_accept && !w_silent && !w_illegal
          && (!w_ws || !r_last_ws);
  end

  assign w_pop = (r_state == S_IDLE) && bus.out_en
              && (r_count != '0);

  always_comb begin
    w_next     = r_state;
    w_gap_load = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_pop)
          w_next = S_EMIT;
      end
      S_EMIT: begin
        if (GAP == 0) begin
          w_next = S_IDLE;
        end else begin
          w_next     = S_GAP;
          w_gap_load = 1'b1;
        end
      end
      S_GAP: begin
        if (r_gap == '0)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst)
      r_state <= S_IDLE;
    else if (bus.flush)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      r_gap <= '0;
    else if (bus.flush)
      r_gap <= '0;
    else if (w_gap_load)
      r_gap <= GW'(GM1);
    else if (r_state == S_GAP && r_gap != '0)
      r_gap <= r_gap - GW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= w_store;
  end

  always_ff @(posedge clk) begin
    if (!rst || bus.flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + ADDR_W'(1);
      if (w_pop)
        r_rptr <= r_rptr + ADDR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ascii_char keeps its last value across flush
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_char  <= '0;
      r_valid <= 1'b0;
      r_eos   <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
      r_eos   <= 1'b0;
    end else if (w_pop) begin
      r_char  <= w_head;
      r_valid <= 1'b1;
      r_eos   <= (w_head == 7'h3B);
    end else begin
      r_valid <= 1'b0;
      r_eos   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      r_last_ws <= 1'b1;
    else if (bus.flush)
      r_last_ws <= 1'b1;
    else if (w_accept && w_ws)
      r_last_ws <= 1'b1;
    else if (w_push)
      r_last_ws <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      r_ill <= 1'b0;
    else if (w_accept && w_illegal)
      r_ill <= 1'b1;
  end

  assign bus.in_ready     = w_ready;
  assign bus.ascii_char   = r_char;
  assign bus.char_valid   = r_valid;
  assign bus.eos          = r_eos;
  assign bus.fifo_count   = r_count;
  assign bus.illegal_char = r_ill;

endmodule

// File: tb/tb_char_stream_feeder.sv
// Bench for char_stream_feeder: string vector table plus scoreboard
// of expected emitted chars, and hand-written full/flush/reset sequences.
module tb_char_stream_feeder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  char_stream_feeder_if #(.ADDR_W(4)) bus();

  char_stream_feeder #(
    .DEPTH(16),
    .ADDR_W(4),
    .GAP(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string din;
    string dout;
    bit    ill;
  } vec_t;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [6:0] sb[$];
  logic       prev_v = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [6:0] e;
    if (rst) begin
      if (bus.char_valid) begin
        chk("spacing", int'(prev_v), 0);
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_char: got 0x%0h, expected none",
                   bus.ascii_char);
        end else begin
          e = sb.pop_front();
          chk("char", int'(bus.ascii_char), int'(e));
          chk("eos", int'(bus.eos), int'(e == 7'h3B));
        end
      end else begin
        chk("eos_idle", int'(bus.eos), 0);
      end
    end
    prev_v = bus.char_valid;
  end

  task automatic push(input logic [6:0] c);
    bit ok;
    ok = 1'b0;
    bus.in_char  = c;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok)
      chk("push_timeout", 0, 1);
  endtask

  task automatic push_str(input string s);
    byte b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      push(b[6:0]);
    end
  endtask

  task automatic expect_str(input string s);
    byte b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      sb.push_back(b[6:0]);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && (sb.size() != 0 || bus.fifo_count != 0); i++)
      @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("drain_left", sb.size(), 0);
    chk("drain_count", int'(bus.fifo_count), 0);
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[6];
    bit   seen;

    vt[0] = '{din: "  if x<5 p<=3 else p<=7;",
              dout: "if x<5 p<=3 else p<=7;", ill: 1'b0};
    vt[1] = '{din: "x\011\012 9\015", dout: "x 9", ill: 1'b0};
    vt[2] = '{din: "p  q\011r ", dout: "p q r ", ill: 1'b0};
    vt[3] = '{din: "a\007b", dout: "ab", ill: 1'b1};
    vt[4] = '{din: "c\177d;", dout: "cd;", ill: 1'b1};
`ifdef FEEDER_CASE_FOLD_EN
    vt[5] = '{din: "IF X", dout: "if x", ill: 1'b1};
`else
    vt[5] = '{din: "IF X", dout: "IF X", ill: 1'b1};
`endif

    bus.in_char  = '0;
    bus.in_valid = 1'b0;
    bus.out_en   = 1'b0;
    bus.flush    = 1'b0;
    rst          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_char_valid", int'(bus.char_valid), 0);
    chk("rst_count", int'(bus.fifo_count), 0);
    chk("rst_illegal", int'(bus.illegal_char), 0);
    chk("rst_ascii", int'(bus.ascii_char), 0);
    @(posedge clk);
    #1;

    // silent drops and leading whitespace never reach the FIFO
    push(7'h00);
    push(7'h0D);
    push(7'h20);
    push(7'h09);
    @(negedge clk);
    chk("silent_count", int'(bus.fifo_count), 0);
    chk("silent_illegal", int'(bus.illegal_char), 0);
    @(posedge clk);
    #1;

    bus.out_en = 1'b1;
    for (int v = 0; v < 6; v++) begin
      do_flush();
      expect_str(vt[v].dout);
      push_str(vt[v].din);
      wait_drain();
      @(negedge clk);
      chk($sformatf("vec%0d_illegal", v), int'(bus.illegal_char),
          int'(vt[v].ill));
      @(posedge clk);
      #1;
    end

    // full FIFO: 16 accepted, 17th held off
    bus.out_en = 1'b0;
    do_flush();
    expect_str("abcdefghijklmnop");
    push_str("abcdefghijklmnop");
    @(negedge clk);
    chk("full_count", int'(bus.fifo_count), 16);
    chk("full_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    bus.in_char  = 7'h71;
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("full_hold_count", int'(bus.fifo_count), 16);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.out_en = 1'b1;
    wait_drain();

    // flush while 'a' is being emitted
    bus.out_en = 1'b0;
    push_str("abc");
    @(negedge clk);
    chk("flush_pre_count", int'(bus.fifo_count), 3);
    @(posedge clk);
    #1;
    sb.push_back(7'h61);
    bus.out_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.char_valid;
    end
    if (!seen)
      chk("flush_wait_a", 0, 1);
    bus.flush = 1'b1;
    #1;
    chk("flush_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", int'(bus.char_valid), 0);
    chk("flush_count", int'(bus.fifo_count), 0);
    repeat (10) @(posedge clk);
    #1;
    chk("flush_sb", sb.size(), 0);
    chk("flush_illegal_kept", int'(bus.illegal_char), 1);

    // reset mid-operation discards everything
    bus.out_en = 1'b0;
    push_str("xyz");
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rrst_count", int'(bus.fifo_count), 0);
    chk("rrst_illegal", int'(bus.illegal_char), 0);
    chk("rrst_valid", int'(bus.char_valid), 0);
    @(posedge clk);
    #1;
    bus.out_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
